// File: rtl/ms_if_pkg.sv
// ---------------------------------------------------------------------------
// ms_if_pkg
// Shared widths, slave register select codes and a small helper for the
// master/slave register-bank slice.
//
// Contents:
//   ADDR_W      transfer address width (2)
//   DATA_W      transfer data width (8)
//   REGC_W      slave register C width (1)
//   REGD_W      slave register D width (4)
//   ADDR_DLY_W  width of the slave's delayed address copy (4)
//   reg_sel_e   address codes that select a slave register
//   addr_to_data()  data word the master emits for a given address
// ---------------------------------------------------------------------------
package ms_if_pkg;

   localparam int unsigned ADDR_W     = 2;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned REGC_W     = 1;
   localparam int unsigned REGD_W     = 4;
   localparam int unsigned ADDR_DLY_W = 4;

   // Codes 4..15 of the delayed address select nothing.
   typedef enum logic [ADDR_DLY_W-1:0] {
      SelRegA = 4'd0,
      SelRegB = 4'd1,
      SelRegC = 4'd2,
      SelRegD = 4'd3
   } reg_sel_e;

   // Master data is four times the address it is leaving, zero-extended.
   function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
      return {{(DATA_W-ADDR_W-2){1'b0}}, a, 2'b00};
   endfunction

endpackage

// File: rtl/ms_if_if.sv
// ---------------------------------------------------------------------------
// ms_if_if
// Transfer bus between the address/data master and the register-bank slave.
//
// Signals:
//   addr    master -> slave  transfer address
//   data    master -> slave  transfer data
//   sready  slave -> master  slave ready; master advances only while high
//
// Modports: master, slave, monitor (observe only).
// ---------------------------------------------------------------------------
interface ms_if_if
   import ms_if_pkg::*;
();

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              sready;

   modport master (
      output addr,
      output data,
      input  sready
   );

   modport slave (
      input  addr,
      input  data,
      output sready
   );

   modport monitor (
      input addr,
      input data,
      input sready
   );

endinterface

// File: rtl/ms_slave.sv
// ---------------------------------------------------------------------------
// ms_slave
// Register-bank slave. Keeps a one-cycle delayed copy of the bus address and
// uses it to decide which register captures the current bus data. Generates
// sready, which stalls the master for one cycle each time it reaches
// address 3.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   bus    slave modport of ms_if_if (addr/data in, sready out)
//   reg_a  out  register A (8 b), written when delayed address is 0
//   reg_b  out  register B (8 b), written when delayed address is 1
//   reg_c  out  register C (1 b), data[0] when delayed address is 2
//   reg_d  out  register D (4 b), data[3:0] when delayed address is 3
// ---------------------------------------------------------------------------
module ms_slave
   import ms_if_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   ms_if_if.slave            bus,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [REGC_W-1:0] reg_c,
   output logic [REGD_W-1:0] reg_d
);

   logic [ADDR_DLY_W-1:0] addr_dly_q, addr_dly_d;
   logic [DATA_W-1:0]     reg_a_q, reg_a_d;
   logic [DATA_W-1:0]     reg_b_q, reg_b_d;
   logic [REGC_W-1:0]     reg_c_q, reg_c_d;
   logic [REGD_W-1:0]     reg_d_q, reg_d_d;
   logic                  dly_q, dly_d;
   logic                  sready;

   // Low only on the first cycle at address 3; dly then drops and releases it.
   assign sready     = ~(bus.addr[1] & bus.addr[0]) | ~dly_q;
   assign bus.sready = sready;

   always_comb begin
      addr_dly_d = {{(ADDR_DLY_W-ADDR_W){1'b0}}, bus.addr};
      dly_d      = sready;
      reg_a_d    = reg_a_q;
      reg_b_d    = reg_b_q;
      reg_c_d    = reg_c_q;
      reg_d_d    = reg_d_q;
      // Write target comes from the address seen one cycle earlier.
      case (addr_dly_q)
         SelRegA: reg_a_d = bus.data;
         SelRegB: reg_b_d = bus.data;
         SelRegC: reg_c_d = bus.data[REGC_W-1:0];
         SelRegD: reg_d_d = bus.data[REGD_W-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_dly_q <= '0;
         reg_a_q    <= '0;
         reg_b_q    <= '0;
         reg_c_q    <= '0;
         reg_d_q    <= '0;
         dly_q      <= 1'b1;
      end else begin
         addr_dly_q <= addr_dly_d;
         reg_a_q    <= reg_a_d;
         reg_b_q    <= reg_b_d;
         reg_c_q    <= reg_c_d;
         reg_d_q    <= reg_d_d;
         dly_q      <= dly_d;
      end
   end

   assign reg_a = reg_a_q;
   assign reg_b = reg_b_q;
   assign reg_c = reg_c_q;
   assign reg_d = reg_d_q;

endmodule

// File: rtl/ms_if_top.sv
// ---------------------------------------------------------------------------
// ms_if_top
// Address/data master plus register-bank slave. The master steps its address
// 0,1,2,3 and wraps, emitting four times the address it leaves as data, and
// holds whenever the slave drops sready.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   addr    out  master transfer address (2 b)
//   data    out  master transfer data (8 b)
//   sready  out  slave ready, combinational
//   reg_a   out  slave register A (8 b)
//   reg_b   out  slave register B (8 b)
//   reg_c   out  slave register C (1 b)
//   reg_d   out  slave register D (4 b)
// ---------------------------------------------------------------------------
module ms_if_top
   import ms_if_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              sready,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [REGC_W-1:0] reg_c,
   output logic [REGD_W-1:0] reg_d
);

   ms_if_if bus ();

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      if (bus.sready) begin
         addr_d = addr_q + 1'b1;  // natural 2-bit wrap 3 -> 0
         data_d = addr_to_data(addr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign bus.addr = addr_q;
   assign bus.data = data_q;

   ms_slave u_slave (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .reg_a (reg_a),
      .reg_b (reg_b),
      .reg_c (reg_c),
      .reg_d (reg_d)
   );

   assign addr   = bus.addr;
   assign data   = bus.data;
   assign sready = bus.sready;

endmodule

// File: tb/tb_ms_if_top.sv
// ---------------------------------------------------------------------------
// tb_ms_if_top
// Table-driven bench for ms_if_top. Each row gives rst for the next edge and
// the outputs expected after it; rows go through a scoreboard queue. A
// negedge monitor checks the stall rules every cycle.
// ---------------------------------------------------------------------------
module tb_ms_if_top;
   import ms_if_pkg::*;

   typedef struct packed {
      logic              rst;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              sready;
      logic [DATA_W-1:0] reg_a;
      logic [DATA_W-1:0] reg_b;
      logic [REGC_W-1:0] reg_c;
      logic [REGD_W-1:0] reg_d;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] reg_a;
   logic [DATA_W-1:0] reg_b;
   logic [REGC_W-1:0] reg_c;
   logic [REGD_W-1:0] reg_d;

   ms_if_if bus ();

   ms_if_top dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (bus.addr),
      .data   (bus.data),
      .sready (bus.sready),
      .reg_a  (reg_a),
      .reg_b  (reg_b),
      .reg_c  (reg_c),
      .reg_d  (reg_d)
   );

   always #5 clk = ~clk;

   int   n_vec  = 0;
   int   n_miss = 0;
   vec_t sb[$];
   vec_t vecs[$];

   // Expected outputs after the k-th edge since reset release (r=1: reset edge).
   function automatic vec_t exp_row(input bit r, input int k);
      vec_t v;
      v        = '0;
      v.rst    = r;
      v.sready = 1'b1;
      if (r) return v;
      case (k)
         1: v.addr = 2'd1;
         2: begin v.addr = 2'd2; v.data = 8'd4; end
         3: begin v.addr = 2'd3; v.data = 8'd8; v.sready = 1'b0; v.reg_b = 8'd4; end
         4: begin v.addr = 2'd3; v.data = 8'd8; v.reg_b = 8'd4; end
         default: begin
            v.reg_b = 8'd4;
            v.reg_d = 4'd12;
            case ((k - 5) % 5)
               0: begin v.addr = 2'd0; v.data = 8'd12; v.reg_d = 4'd8; end
               1: begin v.addr = 2'd1; v.data = 8'd0; end
               2: begin v.addr = 2'd2; v.data = 8'd4; end
               3: begin v.addr = 2'd3; v.data = 8'd8; v.sready = 1'b0; end
               default: begin v.addr = 2'd3; v.data = 8'd8; end
            endcase
         end
      endcase
      return v;
   endfunction

   task automatic check_out(input string name);
      vec_t e;
      n_vec++;
      if (sb.size() == 0) begin
         n_miss++;
         $display("FAIL %s: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      if ({bus.addr, bus.data, bus.sready, reg_a, reg_b, reg_c, reg_d} !==
          {e.addr, e.data, e.sready, e.reg_a, e.reg_b, e.reg_c, e.reg_d}) begin
         n_miss++;
         $display("FAIL %s: got addr=%0d data=%0d sready=%0b a=%0d b=%0d c=%0d d=%0d, want addr=%0d data=%0d sready=%0b a=%0d b=%0d c=%0d d=%0d",
                  name, bus.addr, bus.data, bus.sready, reg_a, reg_b, reg_c, reg_d,
                  e.addr, e.data, e.sready, e.reg_a, e.reg_b, e.reg_c, e.reg_d);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      rst = v.rst;
      sb.push_back(v);
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   // Cycle monitor: stall only at addr 3, master frozen during a stall,
   // data restricted to the four legal values.
   logic              mon_en  = 1'b0;
   logic              mon_arm = 1'b0;
   logic [ADDR_W-1:0] p_addr;
   logic [DATA_W-1:0] p_data;
   logic              p_sready;
   logic              p_rst;

   always @(negedge clk) begin
      if (mon_en) begin
         n_vec++;
         if (!bus.sready && bus.addr != 2'd3) begin
            n_miss++;
            $display("FAIL stall_addr: sready=0 at addr=%0d, want addr=3", bus.addr);
         end
         n_vec++;
         if (!(bus.data inside {8'd0, 8'd4, 8'd8, 8'd12})) begin
            n_miss++;
            $display("FAIL data_range: data=%0d, want one of 0/4/8/12", bus.data);
         end
         if (mon_arm && !p_rst && !p_sready) begin
            n_vec++;
            if (bus.addr !== p_addr || bus.data !== p_data) begin
               n_miss++;
               $display("FAIL stall_hold: addr=%0d data=%0d, want addr=%0d data=%0d",
                        bus.addr, bus.data, p_addr, p_data);
            end
         end
         p_addr   = bus.addr;
         p_data   = bus.data;
         p_sready = bus.sready;
         p_rst    = rst;
         mon_arm  = 1'b1;
      end
   end

   initial begin
      // Reset held 5 cycles, 23 edges of normal run (ends in the addr=3 stall),
      // one reset edge during the stall, then a 10-edge restart.
      for (int i = 0; i < 5; i++) vecs.push_back(exp_row(1'b1, 0));
      for (int k = 1; k <= 23; k++) vecs.push_back(exp_row(1'b0, k));
      vecs.push_back(exp_row(1'b1, 0));
      for (int k = 1; k <= 10; k++) vecs.push_back(exp_row(1'b0, k));

      rst = 1'b1;
      foreach (vecs[i]) begin
         apply(vecs[i], $sformatf("vec%0d", i));
         mon_en = 1'b1;
      end

      // Reset on the second (released) cycle of the addr=3 stall.
      for (int k = 11; k <= 14; k++) apply(exp_row(1'b0, k), $sformatf("pre_rst%0d", k));
      apply(exp_row(1'b1, 0), "rst_stall2");
      // Back-to-back reset edges, then release with no extra cycles.
      apply(exp_row(1'b1, 0), "rst_hold");
      for (int k = 1; k <= 6; k++) apply(exp_row(1'b0, k), $sformatf("restart%0d", k));

      n_vec++;
      if (sb.size() != 0) begin
         n_miss++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ms_if_top.md
MS_IF_TOP -- requirements
Module: ms_if_top

Interface
REQ-001 SHALL have no parameters; all widths are fixed (addr 2 b, data 8 b).
REQ-002 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 addr  output  2  master-driven transfer address.
REQ-005 data  output  8  master-driven transfer data.
REQ-006 sready  output  1  slave-ready, combinational.
REQ-007 reg_a  output  8  slave register A.
REQ-008 reg_b  output  8  slave register B.
REQ-009 reg_c  output  1  slave register C.
REQ-010 reg_d  output  4  slave register D.

Function
REQ-011 Master, rising clk, rst=0, sready=1: addr <= addr+1, mod 4 (3 -> 0); data <= {addr,2'b00}, i.e. 4*old addr, zero-extended to 8 b.
REQ-012 Master, rst=0, sready=0: addr and data hold.
REQ-013 Slave holds a 4-bit addr_dly register; on each edge with rst=0, addr_dly <= zero-extended addr (one-cycle delayed copy).
REQ-014 Slave write on each edge with rst=0 is decoded from the pre-edge addr_dly:
- 0: reg_a <= data
- 1: reg_b <= data
- 2: reg_c <= data[0]
- 3: reg_d <= data[3:0]
- 4..15: no write.
REQ-015 Only the selected register changes; the others hold.
REQ-016 Slave holds a 1-bit dly register; dly <= sready on each edge with rst=0.
REQ-017 sready SHALL equal NOT(addr[1] AND addr[0]) OR NOT dly, purely combinational from the current addr and dly.
REQ-018 When addr=3 and dly=1, sready=0 for exactly one cycle. dly then becomes 0, forcing sready=1, so addr=3 is held for exactly 2 cycles.
REQ-019 Steady-state addr sequence after reset: 0,1,2,3,3,0,1,2,3,3,... (period 5). Matching sready: 1,1,1,0,1.
REQ-020 No other handshake; the master never stalls except via sready.

Reset
REQ-021 While rst=1 at a rising edge, the next state SHALL be: addr=0, data=0, addr_dly=0, reg_a=0, reg_b=0, reg_c=0, reg_d=0, dly=1.
REQ-022 Consequently sready=1 throughout and immediately after reset.
REQ-023 Reset asserted mid-sequence, including during the addr=3 stall, SHALL override all updates on that edge.
REQ-024 Release needs no extra cycles: the first edge with rst=0 performs normal updates.

Structure
REQ-025 A shared package ms_if_pkg SHALL hold ADDR_W=2, DATA_W=8, REGC_W=1 and REGD_W=4.
REQ-026 One sub-module, ms_slave, SHALL hold addr_dly, the register bank, dly and the sready logic.
REQ-027 The master counter/data logic SHALL live in ms_if_top.
REQ-028 All sequential logic SHALL be clocked by clk only; there are no latches.

Verification
REQ-029 Reset release: hold rst=1 for 5 cycles, then drop it.
- During reset: addr=0, data=0, all reg_*=0, sready=1.
- After edges 1, 2, 3: addr=1,2,3 and data=0,4,8.
REQ-030 Stall, continuing from REQ-029: with addr=3 and dly=1, sready=0.
- Next edge: addr=3 and data=8 hold, sready becomes 1.
- Following edge: addr=0, data=12.
REQ-031 Register writes, continuing from REQ-029 (edges counted from release):
- reg_b=4 after edge 3.
- reg_c=0 after edge 4.
- reg_d=8 after edge 5, reg_d=12 after edge 6.
- reg_a stays 0.
REQ-032 Long run, 20 cycles after release:
- addr follows the period-5 pattern of REQ-019.
- sready is low exactly once per period, always while addr=3.
- The master never advances while sready=0.
REQ-033 Mid-run reset: assert rst for 1 cycle while addr=3 and sready=0.
- Next state: addr=0, data=0, all reg_*=0, dly=1, sready=1.
- Sequence restarts per REQ-029.
REQ-034 Wrap check: addr 3 -> 0 never produces a value above 3; data is only ever 0, 4, 8 or 12.
